// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port memory shared by fetch (IF)
// and load/store (DM), DM priority with IF starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_LIM = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic              bus_err,
  output logic              owner_dm
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
  logic              if_ack_q,    if_ack_d;
  logic              dm_ack_q,    dm_ack_d;
  logic              bus_err_q,   bus_err_d;
  logic              owner_dm_q,  owner_dm_d;
  logic [SW-1:0]     starve_q,    starve_d;
  logic [TW-1:0]     tmo_q,       tmo_d;

  logic if_elig;
  logic dm_elig;
  logic grant_if;
  logic grant_dm;
  logic done;
  logic abort;

  // Arbitration: a requester still seeing its ack is not re-granted
  always_comb begin
    if_elig  = if_req & ~if_ack_q;
    dm_elig  = dm_req & ~dm_ack_q;
    grant_dm = dm_elig
             & ~(if_elig & (starve_q == STARVE_MAX));
    grant_if = if_elig & ~grant_dm;
  end

  // Completion sources while BUSY: memory ready or watchdog expiry
  always_comb begin
    done  = (state_q == BUSY) & mem_ready;
    abort = (state_q == BUSY) & ~mem_ready
          & (tmo_q == TMO_LAST);
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    owner_dm_d  = owner_dm_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          owner_dm_d  = 1'b1;
          tmo_d       = '0;
          if (if_elig && starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (grant_if) begin
          state_d    = BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          owner_dm_d = 1'b0;
          tmo_d      = '0;
          starve_d   = '0;
        end
      end

      BUSY: begin
        if (done || abort) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          owner_dm_d = 1'b0;
          bus_err_d  = abort;
          if (owner_dm_q) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = done ? mem_rdata : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = done ? mem_rdata : '0;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared by async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      owner_dm_q  <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      bus_err_q   <= bus_err_d;
      owner_dm_q  <= owner_dm_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign bus_err   = bus_err_q;
  assign owner_dm  = owner_dm_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic
// against a transaction-level reference of the arbiter.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SL = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          bus_err;
  logic          owner_dm;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state (transaction level)
  bit            m_busy;
  bit            m_dm;
  int            m_age;
  int            m_cnt;
  bit            e_if_ack;
  bit            e_dm_ack;
  bit            e_err;
  bit            e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_if_rdata;
  logic [DW-1:0] e_dm_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .STARVE_LIM(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .owner_dm(owner_dm)
  );

  task automatic wait_ack(input int lim, output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (if_ack || dm_ack) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
  endtask

  task automatic test_reset();
    int cyc;
    reset     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 64'h40;
    mem_ready = 1'b1;
    mem_rdata = 64'h1234;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({mem_req, mem_we, if_ack, dm_ack, bus_err, owner_dm,
           mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
        n_fail++;
        $display("FAIL rst_outs t=%0t: req=%b ack=%b/%b addr=%h rd=%h/%h want all 0",
                 $time, mem_req, if_ack, dm_ack, mem_addr, if_rdata, dm_rdata);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h40 || owner_dm !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_first_req: req=%b addr=%h own=%b want 1 40 0",
               mem_req, mem_addr, owner_dm);
    end
    wait_ack(5, cyc);
    n_chk++;
    if (cyc !== 1 || if_ack !== 1'b1 || if_rdata !== 64'h1234) begin
      n_fail++;
      $display("FAIL rst_first_ack: cyc=%0d ack=%b rd=%h want 1 1 1234",
               cyc, if_ack, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_if();
    int cyc;
    if_req    = 1'b1;
    if_addr   = 64'h10;
    mem_rdata = 64'h00500093;
    mem_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h10 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL if_issue: req=%b addr=%h we=%b want 1 10 0",
               mem_req, mem_addr, mem_we);
    end
    if_addr = 64'h999;
    wait_ack(10, cyc);
    n_chk++;
    if (cyc + 2 !== 3) begin
      n_fail++;
      $display("FAIL if_latency: got %0d cycles want 3", cyc + 2);
    end
    n_chk++;
    if (if_ack !== 1'b1 || dm_ack !== 1'b0 || if_rdata !== 64'h00500093) begin
      n_fail++;
      $display("FAIL if_data: ack=%b/%b rd=%h want 1/0 00500093",
               if_ack, dm_ack, if_rdata);
    end
    n_chk++;
    if (mem_addr !== 64'h10) begin
      n_fail++;
      $display("FAIL if_addr_latch: got %h want 10", mem_addr);
    end
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b0 || if_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL if_no_regrant: req=%b ack=%b want 0 0", mem_req, if_ack);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int cyc;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 64'h80;
    dm_wdata = 64'hDEAD;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || owner_dm !== 1'b1 ||
        mem_addr !== 64'h80 || mem_wdata !== 64'hDEAD) begin
      n_fail++;
      $display("FAIL st_issue: req=%b we=%b own=%b addr=%h wd=%h want 1 1 1 80 dead",
               mem_req, mem_we, owner_dm, mem_addr, mem_wdata);
    end
    wait_ack(10, cyc);
    n_chk++;
    if (cyc !== 1 || dm_ack !== 1'b1 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL st_ack: cyc=%0d ack=%b err=%b want 1 1 0", cyc, dm_ack, bus_err);
    end
    n_chk++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 64'h80 ||
        owner_dm !== 1'b0) begin
      n_fail++;
      $display("FAIL st_release: req=%b we=%b addr=%h own=%b want 0 0 80 0",
               mem_req, mem_we, mem_addr, owner_dm);
    end
    dm_req = 1'b0;
    @(negedge clk);
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    mem_rdata = 64'hDEAD;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || owner_dm !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_issue: req=%b we=%b own=%b want 1 0 1", mem_req, mem_we, owner_dm);
    end
    wait_ack(10, cyc);
    n_chk++;
    if (dm_ack !== 1'b1 || dm_rdata !== 64'hDEAD || if_rdata !== 64'h00500093) begin
      n_fail++;
      $display("FAIL ld_data: ack=%b rd=%h if_rd=%h want 1 dead 00500093",
               dm_ack, dm_rdata, if_rdata);
    end
    dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit got[$];
    bit exp_dm;
    int cnt;
    bit prev;
    do_reset();
    mem_ready = 1'b1;
    if_addr   = 64'h200;
    dm_addr   = 64'h300;
    dm_we     = 1'b0;
    if_req    = 1'b1;
    dm_req    = 1'b1;
    prev      = 1'b0;
    for (int i = 0; i < 200 && got.size() < 8; i++) begin
      @(negedge clk);
      if (mem_req && !prev) got.push_back(owner_dm);
      prev = mem_req;
      if (if_ack || dm_ack) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end else begin
        if_req = 1'b1;
        dm_req = 1'b1;
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    n_chk++;
    if (got.size() != 8) begin
      n_fail++;
      $display("FAIL starve_count: got %0d grants want 8", got.size());
    end
    cnt = 0;
    for (int k = 0; k < got.size(); k++) begin
      if (cnt == SL) begin
        exp_dm = 1'b0;
        cnt    = 0;
      end else begin
        exp_dm = 1'b1;
        cnt    = cnt + 1;
      end
      n_chk++;
      if (got[k] !== exp_dm) begin
        n_fail++;
        $display("FAIL starve_order[%0d]: owner_dm=%b want %b", k, got[k], exp_dm);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int bad;
    int cyc;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 64'h88;
    mem_ready = 1'b0;
    mem_rdata = 64'hBAD;
    bad       = 0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || dm_ack !== 1'b0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL tmo_busy: %0d bad busy cycles want 0", bad);
    end
    @(negedge clk);
    n_chk++;
    if (dm_ack !== 1'b1 || bus_err !== 1'b1 || dm_rdata !== '0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_abort: ack=%b err=%b rd=%h req=%b want 1 1 0 0",
               dm_ack, bus_err, dm_rdata, mem_req);
    end
    dm_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus_err !== 1'b0 || dm_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_pulse: err=%b ack=%b want 0 0", bus_err, dm_ack);
    end
    if_req    = 1'b1;
    if_addr   = 64'h20;
    mem_ready = 1'b1;
    mem_rdata = 64'h13;
    wait_ack(10, cyc);
    n_chk++;
    if (cyc !== 2 || if_ack !== 1'b1 || bus_err !== 1'b0 || if_rdata !== 64'h13) begin
      n_fail++;
      $display("FAIL tmo_after_if: cyc=%0d ack=%b err=%b rd=%h want 2 1 0 13",
               cyc, if_ack, bus_err, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 64'h100;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || dm_ack !== 1'b0 || owner_dm !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_drop: req=%b ack=%b own=%b want 0 0 0",
               mem_req, dm_ack, owner_dm);
    end
    @(negedge clk);
    n_chk++;
    if (dm_ack !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_hold: ack=%b req=%b want 0 0", dm_ack, mem_req);
    end
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 64'h77;
    wait_ack(10, cyc);
    n_chk++;
    if (cyc !== 2 || dm_ack !== 1'b1 || dm_rdata !== 64'h77 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_reissue: cyc=%0d ack=%b rd=%h err=%b want 2 1 77 0",
               cyc, dm_ack, dm_rdata, bus_err);
    end
    dm_req = 1'b0;
    @(negedge clk);
  endtask

  // one clock of the reference, applied with inputs stable at posedge
  task automatic model_step();
    bit n_ia, n_da, n_err, ie, de, gdm;
    n_ia  = 1'b0;
    n_da  = 1'b0;
    n_err = 1'b0;
    if (m_busy) begin
      m_age++;
      if (mem_ready || m_age == TO) begin
        if (m_dm) begin
          n_da       = 1'b1;
          e_dm_rdata = mem_ready ? mem_rdata : '0;
        end else begin
          n_ia       = 1'b1;
          e_if_rdata = mem_ready ? mem_rdata : '0;
        end
        n_err  = !mem_ready;
        m_busy = 1'b0;
        m_dm   = 1'b0;
        e_we   = 1'b0;
      end
    end else begin
      ie = if_req && !e_if_ack;
      de = dm_req && !e_dm_ack;
      if (ie || de) begin
        gdm = de && !(ie && m_cnt == SL);
        if (gdm) begin
          if (ie) m_cnt = (m_cnt + 1 > SL) ? SL : m_cnt + 1;
          e_addr  = dm_addr;
          e_wdata = dm_wdata;
          e_we    = dm_we;
        end else begin
          m_cnt  = 0;
          e_addr = if_addr;
          e_we   = 1'b0;
        end
        m_busy = 1'b1;
        m_dm   = gdm;
        m_age  = 0;
      end
    end
    e_if_ack = n_ia;
    e_dm_ack = n_da;
    e_err    = n_err;
  endtask

  task automatic test_random();
    do_reset();
    m_busy = 0; m_dm = 0; m_age = 0; m_cnt = 0;
    e_if_ack = 0; e_dm_ack = 0; e_err = 0; e_we = 0;
    e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
    for (int c = 0; c < 800; c++) begin
      if (c != 0) begin
        n_chk++;
        if ({mem_req, owner_dm, if_ack, dm_ack, bus_err, mem_we} !==
            {m_busy, m_busy && m_dm, e_if_ack, e_dm_ack, e_err, e_we}) begin
          n_fail++;
          $display("FAIL rnd_ctl c=%0d: req/own/ia/da/err/we=%b want %b", c,
                   {mem_req, owner_dm, if_ack, dm_ack, bus_err, mem_we},
                   {m_busy, m_busy && m_dm, e_if_ack, e_dm_ack, e_err, e_we});
        end
        n_chk++;
        if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
          n_fail++;
          $display("FAIL rnd_bus c=%0d: addr=%h wd=%h want %h %h",
                   c, mem_addr, mem_wdata, e_addr, e_wdata);
        end
        n_chk++;
        if (if_rdata !== e_if_rdata || dm_rdata !== e_dm_rdata) begin
          n_fail++;
          $display("FAIL rnd_rdata c=%0d: if=%h dm=%h want %h %h",
                   c, if_rdata, dm_rdata, e_if_rdata, e_dm_rdata);
        end
      end
      if (if_req) begin
        if (if_ack && ($urandom % 2 == 0)) if_req = 1'b0;
      end else if ($urandom % 3 == 0) begin
        if_req = 1'b1;
      end
      if (dm_req) begin
        if (dm_ack && ($urandom % 2 == 0)) dm_req = 1'b0;
      end else if ($urandom % 3 == 0) begin
        dm_req = 1'b1;
      end
      if_addr   = {$urandom, $urandom};
      dm_addr   = {$urandom, $urandom};
      dm_wdata  = {$urandom, $urandom};
      dm_we     = 1'($urandom % 2);
      mem_rdata = {$urandom, $urandom};
      if ((c % 150) >= 100 && (c % 150) < 120) mem_ready = 1'b0;
      else mem_ready = ($urandom % 4 != 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    test_reset();
    test_single_if();
    test_store_load();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch path (IF) and load/store path (DM).
- Sits between the RISC_V core and the memory model, replacing the separate instruction and data memory ports.
- Handles request/ack handshakes, DM-priority arbitration with IF starvation protection, and a memory-ready timeout.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- STARVE_LIM, 3, number of consecutive DM grants made while IF is waiting; after this many, IF is forced to win.
- TIMEOUT, 15, maximum cycles in BUSY without mem_ready before the transaction aborts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for IF.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid while dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse for DM.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completes the current transaction.
- bus_err  out  1  pulses together with the ack of a timed-out transaction.
- owner_dm  out  1  1 while a DM transaction owns the port.

Behaviour:
- Reset: all outputs are registered and clear to 0 when reset is low. FSM goes to IDLE; starvation and timeout counters clear.
- Reset asserted mid-transaction drops the transaction with no ack.
- FSM states: IDLE, BUSY.
- IDLE, no eligible request: stay in IDLE.
- IDLE, with an eligible request: latch owner, address, we and wdata, then go to BUSY.
  - mem_req=1 and mem_* fields drive the latched values starting the next cycle.
  - IF latches always carry we=0.
- Eligibility: a requester whose ack is high this cycle is ignored. This prevents re-granting a request whose req has not yet dropped.
- Arbitration:
  - Only one requester eligible: grant it.
  - Both eligible: DM wins unless starve_cnt==STARVE_LIM, in which case IF wins.
  - starve_cnt increments (saturating) on each DM grant made while if_req is eligible. It clears on every IF grant.
- BUSY, normal completion: on the rising edge where mem_ready=1:
  - register mem_rdata into the owner's rdata;
  - pulse the owner's ack for exactly one cycle;
  - drop mem_req and mem_we;
  - return to IDLE.
- BUSY timeout: tmo_cnt counts BUSY cycles. If it reaches TIMEOUT with mem_ready still 0:
  - abort the transaction;
  - pulse the owner's ack and bus_err together;
  - rdata is 0;
  - return to IDLE.
- mem_ready in IDLE is ignored.
- Latency: request sampled at edge N → mem_req high in cycle N+1. Ready sampled at edge M → ack high in cycle M+1. Minimum request-to-ack is 3 cycles with zero-wait memory. There is one IDLE turnaround cycle between transactions.
- rdata holds its last value between acks. mem_addr and mem_wdata hold their last values when mem_req=0.
- owner_dm mirrors the latched owner during BUSY and is 0 in IDLE.
- Requests changing address mid-transaction have no effect; the latched copy is used.

Test Plan:
- Reset: hold reset low 25 ns with if_req=1 → all outputs stay 0. After release, mem_req rises 1 cycle after the first sampled edge, with mem_addr equal to if_addr.
- Single IF, zero-wait memory: if_addr=0x10, mem_rdata=0x00500093, mem_ready=1 while BUSY → if_ack pulses once, 3 cycles after the request, with if_rdata=0x00500093. No second grant occurs.
- Store then load: DM store addr=0x80, wdata=0xDEAD → mem_we=1, mem_wdata=0xDEAD, dm_ack. Then a DM load from 0x80 with mem_rdata=0xDEAD → dm_rdata=0xDEAD, mem_we=0.
- Starvation: if_req and dm_req held continuously, with dm_req re-issued after each ack → grant order is DM,DM,DM,IF,DM… and starve_cnt clears after the IF grant.
- Timeout: DM load with mem_ready held 0 → after 15 BUSY cycles, dm_ack=1 and bus_err=1 in the same cycle, dm_rdata=0, FSM returns to IDLE. A following IF request then proceeds normally.
- Reset mid-BUSY: assert reset 2 cycles into a DM transaction → no dm_ack and mem_req=0 immediately. After release, the re-issued request completes normally.
